// File: rtl/aurora_pkg.sv
// Shared character codes, state type and classifier for the Aurora idle monitor.
package aurora_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // K
    localparam logic [7:0] K28_3 = 8'h7C;  // A
    localparam logic [7:0] K28_0 = 8'h1C;  // R

    localparam int A_MIN_DEF    = 17;
    localparam int A_MAX_DEF    = 32;
    localparam int LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        LOCKED
    } idle_mon_state_t;

    typedef enum logic [2:0] {
        CH_DATA,
        CH_K,
        CH_A,
        CH_R,
        CH_UNK
    } char_class_t;

    function automatic char_class_t classify(input logic is_k, input logic [7:0] data);
        char_class_t cls;
        if (!is_k) begin
            cls = CH_DATA;
        end else begin
            case (data)
                K28_5:   cls = CH_K;
                K28_3:   cls = CH_A;
                K28_0:   cls = CH_R;
                default: cls = CH_UNK;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/a_spacing_counter.sv
// Counts valid idle characters since the last A and flags short or overlong A intervals.
module a_spacing_counter
    import aurora_pkg::*;
#(
    parameter int A_MIN = A_MIN_DEF,
    parameter int A_MAX = A_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic is_a,
    input  logic is_idle,
    output logic a_short,
    output logic a_in_range,
    output logic sat_hit
);

    localparam int CNT_W = $clog2(A_MAX + 2);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(A_MIN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(A_MAX);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(A_MAX + 1);

    // Zero means no interval in progress: no A seen since the last non-idle character.
    logic [CNT_W-1:0] count;
    logic             tracking;

    always_comb begin
        tracking   = (count != '0);
        a_short    = valid && is_a && tracking && (count < MIN_C);
        a_in_range = valid && is_a && tracking && (count >= MIN_C) && (count <= MAX_C);
        sat_hit    = valid && is_idle && !is_a && (count == MAX_C);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (valid) begin
            if (is_a) begin
                count <= CNT_W'(1);
            end else if (!is_idle) begin
                count <= '0;
            end else if (tracking && (count != SAT_C)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/idle_monitor.sv
// Receive-side idle ordered-set monitor: K/A/R classification, K-first and A-cadence checks.
// Optional saturating error counter enabled by defining IDLE_MONITOR_ERR_CNT_EN.
module idle_monitor
    import aurora_pkg::*;
#(
    parameter int A_MIN    = A_MIN_DEF,
    parameter int A_MAX    = A_MAX_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_is_k,
    input  logic       rx_code_err,
    output logic       rx_K,
    output logic       rx_A,
    output logic       rx_R,
    output logic       rx_idle,
    output logic       idle_locked,
    output logic       seq_err,
    output logic       spacing_err,
    output logic       unk_k_err,
    output logic [7:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_CNT);

    idle_mon_state_t   state, state_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic              after_non_idle, after_non_idle_nxt;

    char_class_t ch;
    logic        is_k, is_a, is_r, is_idle, is_unk, code_err;
    logic        seq_nxt, spacing_nxt, unk_nxt;
    logic        a_short, a_in_range, sat_hit;

    always_comb begin
        ch       = classify(rx_is_k, rx_data);
        is_k     = rx_valid && (ch == CH_K);
        is_a     = rx_valid && (ch == CH_A);
        is_r     = rx_valid && (ch == CH_R);
        is_unk   = rx_valid && (ch == CH_UNK);
        is_idle  = is_k || is_a || is_r;
        code_err = rx_valid && rx_code_err;
    end

    a_spacing_counter #(
        .A_MIN (A_MIN),
        .A_MAX (A_MAX)
    ) u_spacing (
        .clk        (clk),
        .rst        (rst),
        .valid      (rx_valid),
        .is_a       (is_a),
        .is_idle    (is_idle),
        .a_short    (a_short),
        .a_in_range (a_in_range),
        .sat_hit    (sat_hit)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt          = state;
        good_nxt           = good;
        after_non_idle_nxt = after_non_idle;
        seq_nxt            = 1'b0;
        spacing_nxt        = 1'b0;
        unk_nxt            = is_unk;

        if (rx_valid) begin
            seq_nxt            = (is_a || is_r) && after_non_idle;
            after_non_idle_nxt = !is_idle;
            spacing_nxt        = (a_short || sat_hit) && (state != HUNT);

            case (state)
                HUNT: begin
                    if (is_a) begin
                        state_nxt = TRACK;
                        good_nxt  = '0;
                    end else if (code_err) begin
                        good_nxt = '0;
                    end
                end
                TRACK: begin
                    if (!is_idle || spacing_nxt) begin
                        state_nxt = HUNT;
                    end else if (code_err) begin
                        good_nxt = '0;
                    end else if (a_in_range) begin
                        good_nxt = good + 1'b1;
                        if (good_nxt == LOCK_C) state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    // Plain data keeps lock; the counter restarts silently on the next A.
                    if (spacing_nxt || code_err || is_unk) state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= HUNT;
            good           <= '0;
            after_non_idle <= 1'b0;
        end else begin
            state          <= state_nxt;
            good           <= good_nxt;
            after_non_idle <= after_non_idle_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_K        <= 1'b0;
            rx_A        <= 1'b0;
            rx_R        <= 1'b0;
            rx_idle     <= 1'b0;
            idle_locked <= 1'b0;
            seq_err     <= 1'b0;
            spacing_err <= 1'b0;
            unk_k_err   <= 1'b0;
        end else begin
            rx_K        <= is_k;
            rx_A        <= is_a;
            rx_R        <= is_r;
            seq_err     <= seq_nxt;
            spacing_err <= spacing_nxt;
            unk_k_err   <= unk_nxt;
            idle_locked <= (state_nxt == LOCKED);
            if (rx_valid) rx_idle <= is_idle;
        end
    end

`ifdef IDLE_MONITOR_ERR_CNT_EN
    logic any_err;
    assign any_err = seq_nxt || spacing_nxt || unk_nxt || code_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (any_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_idle_monitor.sv
// Self-checking bench for idle_monitor: directed scenarios plus random traffic vs a behavioural model.
module tb_idle_monitor;

    localparam int A_MIN    = 17;
    localparam int A_MAX    = 32;
    localparam int LOCK_CNT = 4;
    localparam logic [7:0] CK = 8'hBC;
    localparam logic [7:0] CA = 8'h7C;
    localparam logic [7:0] CR = 8'h1C;
`ifdef IDLE_MONITOR_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_is_k = 1'b0;
    logic       rx_code_err = 1'b0;
    logic       rx_K, rx_A, rx_R, rx_idle, idle_locked, seq_err, spacing_err, unk_k_err;
    logic [7:0] err_count;

    idle_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_is_k     (rx_is_k),
        .rx_code_err (rx_code_err),
        .rx_K        (rx_K),
        .rx_A        (rx_A),
        .rx_R        (rx_R),
        .rx_idle     (rx_idle),
        .idle_locked (idle_locked),
        .seq_err     (seq_err),
        .spacing_err (spacing_err),
        .unk_k_err   (unk_k_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: positions are counts of valid characters; an A interval is the
    // distance between two A positions with no non-idle character in between.
    int         m_vidx, m_last_a, m_mode, m_good, ival;
    bit         m_after;
    bit         c_k, c_a, c_r, c_idle, c_unk, c_short, c_rng, c_sat;
    logic       e_K, e_A, e_R, e_idle, e_locked, e_seq, e_sp, e_unk;
    logic [7:0] e_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vidx = 0; m_last_a = -1; m_mode = 0; m_good = 0; m_after = 0;
            {e_K, e_A, e_R, e_idle, e_locked, e_seq, e_sp, e_unk} = '0;
            e_err = 8'd0;
        end else begin
            {e_K, e_A, e_R, e_seq, e_sp, e_unk} = '0;
            if (rx_valid) begin
                m_vidx++;
                c_k    = rx_is_k && rx_data == CK;
                c_a    = rx_is_k && rx_data == CA;
                c_r    = rx_is_k && rx_data == CR;
                c_idle = c_k || c_a || c_r;
                c_unk  = rx_is_k && !c_idle;
                ival   = (m_last_a >= 0) ? m_vidx - m_last_a : 0;
                c_short = c_a && m_last_a >= 0 && ival < A_MIN;
                c_rng   = c_a && m_last_a >= 0 && ival >= A_MIN && ival <= A_MAX;
                // Once A_MAX idles follow an A, any later A is necessarily too late.
                c_sat   = c_idle && !c_a && m_last_a >= 0 && ival == A_MAX;
                e_K = c_k; e_A = c_a; e_R = c_r; e_unk = c_unk; e_idle = c_idle;
                e_seq   = (c_a || c_r) && m_after;
                m_after = !c_idle;
                e_sp    = (c_short || c_sat) && m_mode != 0;
                if (c_a) m_last_a = m_vidx;
                else if (!c_idle) m_last_a = -1;
                case (m_mode)
                    0: if (c_a) begin m_mode = 1; m_good = 0; end
                    1: begin
                        if (!c_idle || e_sp) m_mode = 0;
                        else if (rx_code_err) m_good = 0;
                        else if (c_rng) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_mode = 2;
                        end
                    end
                    default: if (e_sp || rx_code_err || c_unk) m_mode = 0;
                endcase
                if (ERR_EN && (e_seq || e_sp || e_unk || rx_code_err) && e_err != 8'hFF)
                    e_err = e_err + 8'd1;
            end
            e_locked = (m_mode == 2);
        end
    end

    always @(negedge clk) begin
        check("cycle_outputs",
              {16'h0, rx_K, rx_A, rx_R, rx_idle, idle_locked, seq_err, spacing_err, unk_k_err, err_count},
              {16'h0, e_K, e_A, e_R, e_idle, e_locked, e_seq, e_sp, e_unk, e_err});
    end

    task automatic put(input logic v, input logic [7:0] d, input logic k, input logic ce);
        rx_valid = v; rx_data = d; rx_is_k = k; rx_code_err = ce;
        @(posedge clk);
        #2;
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    endtask
    task automatic send_r(input int n);
        for (int i = 0; i < n; i++) put(1'b1, CR, 1'b1, 1'b0);
    endtask
    task automatic send_a();
        put(1'b1, CA, 1'b1, 1'b0);
    endtask
    task automatic relock();
        send_a();
        for (int i = 0; i < LOCK_CNT; i++) begin
            send_r(19);
            send_a();
        end
    endtask

    int sp_sum, sp_idx, r, since, target;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("reset_outputs", {rx_K, rx_A, rx_R, rx_idle, idle_locked, seq_err, spacing_err, unk_k_err, err_count}, 16'h0);
        check("model_reset", {e_locked, e_sp, e_err}, 10'h0);

        // 1: data, K, 20 R, A, then A every 20 idles
        send_data(8);
        put(1'b1, CK, 1'b1, 1'b0);
        check("k_pulse", {rx_K, seq_err}, 2'b10);
        send_r(20);
        send_a();
        check("first_a", {rx_A, idle_locked, seq_err}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            send_r(19);
            send_a();
            if (i == 2) check("not_yet_locked", {idle_locked, e_locked}, 2'b00);
            if (i == 3) check("locked_5th_a", {idle_locked, e_locked, spacing_err}, 3'b110);
        end

        // 2: short interval while locked
        send_r(9);
        send_a();
        check("short_a", {spacing_err, idle_locked, e_sp}, 3'b101);

        // 3: relock, then no A for 40 idles
        relock();
        check("relocked", idle_locked, 1'b1);
        sp_sum = 0; sp_idx = 0;
        for (int i = 1; i <= 40; i++) begin
            send_r(1);
            if (spacing_err) begin sp_sum++; sp_idx = i; end
        end
        check("sat_pulses", sp_sum, 1);
        check("sat_index", sp_idx, A_MAX);
        check("sat_unlock", {idle_locked, e_locked}, 2'b00);

        // 4: idle run not starting with K
        send_data(1);
        send_a();
        check("seq_a", {seq_err, e_seq}, 2'b11);
        send_r(1);
        check("seq_once", seq_err, 1'b0);
        send_data(1);
        send_r(1);
        check("seq_r", seq_err, 1'b1);
        send_data(1);
        put(1'b1, CK, 1'b1, 1'b0);
        send_r(1);
        check("k_first_ok", seq_err, 1'b0);

        // 5: unknown K, then a long valid gap mid-interval
        put(1'b1, 8'hFC, 1'b1, 1'b0);
        check("unk_k", {unk_k_err, rx_idle}, 2'b10);
        relock();
        send_r(10);
        for (int i = 0; i < 50; i++) put(1'b0, CA, 1'b1, 1'b0);
        check("gap_hold", {idle_locked, rx_idle, rx_R, spacing_err}, 4'b1100);
        send_r(9);
        send_a();
        check("gap_resume", {spacing_err, idle_locked}, 2'b01);
        put(1'b1, 8'hF7, 1'b1, 1'b0);
        check("unk_unlock", {unk_k_err, idle_locked}, 2'b10);

        // 6: error counter saturation and async reset while locked
        for (int i = 0; i < 300; i++) put(1'b1, 8'hFC, 1'b1, 1'b0);
        check("err_sat", err_count, ERR_EN ? 8'd255 : 8'd0);
        put(1'b1, CK, 1'b1, 1'b0);
        relock();
        check("pre_rst_lock", idle_locked, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst", {rx_K, rx_A, rx_R, rx_idle, idle_locked, seq_err, spacing_err, unk_k_err, err_count}, 16'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Random traffic
        since = 0;
        target = 20;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 6) begin
                put(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 8) begin
                put(1'b1, 8'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0));
            end else if (r < 9) begin
                put(1'b1, (r[0] ? 8'hFC : 8'hF7), 1'b1, 1'b0);
            end else if (since + 1 >= target) begin
                put(1'b1, CA, 1'b1, r < 11);
                since = 0;
                target = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 45) : $urandom_range(A_MIN, A_MAX);
            end else begin
                put(1'b1, (r[0] ? CK : CR), 1'b1, r < 10);
                since++;
            end
        end

        put(1'b0, 8'h00, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
